clk_div_int: RTL and testbench

// - Integer clock divider: derives o_div_clk from i_ref_clk, dividing by a runtime 8-bit ratio.
// - Sits in the clock-generation path, e.g. feeding a UART/peripheral clock domain from the reference clock.
// - Bypasses (passes i_ref_clk straight through) when disabled or when the ratio is 0 or 1.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_int_if.sv | 15 +
 rtl/clk_div_cnt.sv | 55 +++++
 rtl/clk_div_int.sv | 48 ++++
 tb/tb_clk_div_int.sv | 119 +++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Package clk_div_pkg: shared types for the integer clock divider.
//   RATIO_WD : default width of the division ratio and the cycle counter
//   ratio_t  : ratio / counter type at the default width
//   mode_t   : decoded operating mode (BYPASS, DIV_EVEN, DIV_ODD)
package clk_div_pkg;

    localparam int RATIO_WD = 8;

    typedef logic [RATIO_WD-1:0] ratio_t;

    typedef enum logic [1:0] {
        BYPASS   = 2'd0,
        DIV_EVEN = 2'd1,
        DIV_ODD  = 2'd2
    } mode_t;

endpackage

// File: rtl/clk_div_int_if.sv
// Interface clk_div_int_if: control and output bundle of the clock divider.
//   i_clk_en    : 1 = divide, 0 = bypass
//   i_div_ratio : division ratio N (unsigned)
//   o_div_clk   : divided (or bypassed) clock
// Modports: master (drives control, observes clock), slave (the divider).
interface clk_div_int_if #(
    parameter int RATIO_WD = clk_div_pkg::RATIO_WD
);
    logic                i_clk_en;
    logic [RATIO_WD-1:0] i_div_ratio;
    logic                o_div_clk;

    modport master (output i_clk_en, output i_div_ratio, input  o_div_clk);
    modport slave  (input  i_clk_en, input  i_div_ratio, output o_div_clk);
endinterface

// File: rtl/clk_div_cnt.sv
// Module clk_div_cnt: phase counter, phase-length compare and toggle register.
//   i_ref_clk : reference clock (rising edge)
//   i_rst     : asynchronous active-low reset
//   i_mode    : decoded mode; BYPASS holds counter and register at 0
//   i_ratio   : effective ratio N (already LSB-masked when odd ratios are off)
//   o_div     : toggle register output
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter int RATIO_WD = clk_div_pkg::RATIO_WD
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  mode_t               i_mode,
    input  logic [RATIO_WD-1:0] i_ratio,
    output logic                o_div
);

    logic [RATIO_WD-1:0] cnt_q;
    logic                div_q;
    logic [RATIO_WD:0]   ratio_x;
    logic [RATIO_WD:0]   phase_len;
    logic [RATIO_WD-1:0] limit;
    logic                active;

    assign active = (i_mode != BYPASS);

    // Low phase is ceil(N/2), high phase floor(N/2); for even N both are N/2.
    // One extra bit keeps N+1 from overflowing at the maximum ratio.
    always_comb begin
        ratio_x   = {1'b0, i_ratio};
        phase_len = div_q ? (ratio_x >> 1) : ((ratio_x + 1'b1) >> 1);
        limit     = RATIO_WD'(phase_len - 1'b1);
    end

    // >= rather than == so a ratio decrease mid-phase ends the phase on the
    // next edge instead of letting the counter run around.
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (!active) begin
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (cnt_q >= limit) begin
            cnt_q <= '0;
            div_q <= ~div_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_div = div_q;

endmodule

// File: rtl/clk_div_int.sv
// Module clk_div_int: runtime-programmable integer clock divider.
//   i_ref_clk : reference clock
//   i_rst     : asynchronous active-low reset
//   bus       : clk_div_int_if.slave (i_clk_en, i_div_ratio in; o_div_clk out)
// Divides when i_clk_en=1 and N>=2, otherwise passes i_ref_clk straight through.
// Build option: CLK_DIV_ODD_EN enables exact odd ratios; without it the ratio
// LSB is ignored so odd N divides by N-1 at 50% duty.
module clk_div_int
    import clk_div_pkg::*;
#(
    parameter int RATIO_WD = clk_div_pkg::RATIO_WD
) (
    input  logic         i_ref_clk,
    input  logic         i_rst,
    clk_div_int_if.slave bus
);

    mode_t               mode;
    logic [RATIO_WD-1:0] eff_ratio;
    logic                div_q;

    // Bypass is decided on the raw ratio, so N=1 bypasses in both builds.
    always_comb begin
        mode      = BYPASS;
`ifdef CLK_DIV_ODD_EN
        eff_ratio = bus.i_div_ratio;
        if (bus.i_clk_en && (bus.i_div_ratio >= RATIO_WD'(2)))
            mode = bus.i_div_ratio[0] ? DIV_ODD : DIV_EVEN;
`else
        eff_ratio = {bus.i_div_ratio[RATIO_WD-1:1], 1'b0};
        if (bus.i_clk_en && (bus.i_div_ratio >= RATIO_WD'(2)))
            mode = DIV_EVEN;
`endif
    end

    clk_div_cnt #(.RATIO_WD(RATIO_WD)) u_cnt (
        .i_ref_clk (i_ref_clk),
        .i_rst     (i_rst),
        .i_mode    (mode),
        .i_ratio   (eff_ratio),
        .o_div     (div_q)
    );

    // Only the mode select reaches the mux from the ratio input; in divide
    // mode the output is purely the register.
    assign bus.o_div_clk = (mode == BYPASS) ? i_ref_clk : div_q;

endmodule

// File: tb/tb_clk_div_int.sv
// Testbench tb_clk_div_int: directed and random ratio/enable settings checked
// edge by edge against an arithmetic model of the divided waveform.
module tb_clk_div_int;

    logic ref_clk = 1'b0;
    logic rst     = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    always #5 ref_clk = ~ref_clk;

    clk_div_int_if #(.RATIO_WD(8)) bus ();

    clk_div_int dut (
        .i_ref_clk (ref_clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    function automatic bit is_bypass(input int n, input bit en);
        return !en || n < 2;
    endfunction

    // Level just after the k-th rising ref edge since reset release, in divide
    // mode: within each period of N edges the first ceil(N/2) positions are low.
    function automatic logic model_div(input int n, input int k);
        int ne, lo;
`ifdef CLK_DIV_ODD_EN
        ne = n;
`else
        ne = n - (n % 2);
`endif
        lo = (ne + 1) / 2;
        return ((k % ne) >= lo);
    endfunction

    // Settings applied and reset held low; check the reset level, release at
    // a falling edge, then check both clock phases for the given edge count.
    task automatic release_and_run(input string tag, input int n, input bit en,
                                   input int edges, input int k0);
        logic exp;
        @(posedge ref_clk); #1;
        chk({tag, "_rst"}, bus.o_div_clk, is_bypass(n, en) ? 1'b1 : 1'b0);
        @(negedge ref_clk);
        rst = 1'b1;
        for (int k = k0 + 1; k <= k0 + edges; k++) begin
            @(posedge ref_clk); #1;
            exp = is_bypass(n, en) ? 1'b1 : model_div(n, k);
            chk({tag, "_hi"}, bus.o_div_clk, exp);
            @(negedge ref_clk); #1;
            exp = is_bypass(n, en) ? 1'b0 : model_div(n, k);
            chk({tag, "_lo"}, bus.o_div_clk, exp);
        end
    endtask

    task automatic run_seg(input string tag, input int n, input bit en, input int edges);
        @(negedge ref_clk);
        rst             = 1'b0;
        bus.i_clk_en    = en;
        bus.i_div_ratio = 8'(n);
        release_and_run(tag, n, en, edges, 0);
    endtask

    initial begin
        int n, edges;
        bit en;
        bus.i_clk_en    = 1'b0;
        bus.i_div_ratio = '0;
        #1;
        chk("reset_bypass_low", bus.o_div_clk, 1'b0);

        run_seg("n3",   3,   1'b1, 12);
        run_seg("n4",   4,   1'b1, 12);
        run_seg("n2",   2,   1'b1, 8);
        run_seg("n255", 255, 1'b1, 520);
        run_seg("en0",  7,   1'b0, 6);
        run_seg("n0",   0,   1'b1, 6);
        run_seg("n1",   1,   1'b1, 6);
        run_seg("n5",   5,   1'b1, 15);

        // Reset asserted in the middle of a high phase with N=6.
        run_seg("n6", 6, 1'b1, 4);
        @(posedge ref_clk); #1;
        chk("n6_prehigh", bus.o_div_clk, 1'b1);
        #1 rst = 1'b0;
        #1 chk("n6_async_rst", bus.o_div_clk, 1'b0);
        release_and_run("n6_rel", 6, 1'b1, 12, 0);

        // Ratio drop 8 -> 2 two edges into the first low phase: the phase ends
        // on the next edge, then the output toggles every edge.
        run_seg("n8", 8, 1'b1, 2);
        bus.i_div_ratio = 8'd2;
        for (int k = 0; k < 6; k++) begin
            @(posedge ref_clk); #1;
            chk("n8to2", bus.o_div_clk, (k % 2 == 0) ? 1'b1 : 1'b0);
        end

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) n = $urandom_range(0, 3);
            else if ($urandom_range(0, 7) == 0) n = $urandom_range(41, 255);
            else n = $urandom_range(2, 40);
            en    = ($urandom_range(0, 3) != 0);
            edges = (n >= 2) ? (2 * n + 6) : 10;
            run_seg("rnd", n, en, edges);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
